// File: rtl/reg_file_sb_if.sv
// Port bundle for reg_file_sb: two read ports, ALU write port, load write port,
// load-issue port and the registered busy count.
interface reg_file_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rv1;
    logic              rv2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              lwe;
    logic [ADDR_W-1:0] lwa;
    logic [DATA_W-1:0] lwd;
    logic              iss;
    logic [ADDR_W-1:0] iwa;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output ra1, ra2, we, wa, wd, lwe, lwa, lwd, iss, iwa,
        input  rd1, rd2, rv1, rv2, busy_cnt
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, lwe, lwa, lwd, iss, iwa,
        output rd1, rd2, rv1, rv2, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-write-port register file with pending-load scoreboard and optional
// same-cycle write-to-read forwarding.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic we_ok;
    logic lwe_ok;
    logic iss_ok;
    logic set_new;
    logic clr_old;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Hardwired-zero register swallows every write and issue.
    always_comb begin
        we_ok  = bus.we  && !is_zero(bus.wa);
        lwe_ok = bus.lwe && !is_zero(bus.lwa);
        iss_ok = bus.iss && !is_zero(bus.iwa);
    end

    // Port A applied after port B so the younger ALU result wins; busy set after clear.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (lwe_ok) begin
            rf_d[bus.lwa]   = bus.lwd;
            busy_d[bus.lwa] = 1'b0;
        end
        if (we_ok) begin
            rf_d[bus.wa] = bus.wd;
        end
        if (iss_ok) begin
            busy_d[bus.iwa] = 1'b1;
        end
    end

    // Count only real transitions so re-issue and set/clear collisions net out.
    always_comb begin
        set_new = iss_ok && !busy_q[bus.iwa];
        clr_old = lwe_ok && busy_q[bus.lwa] && !(iss_ok && (bus.iwa == bus.lwa));
        cnt_d   = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rd [2];
    logic              rv [2];

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        // Forwarding is held off during reset so reads show the cleared array.
        always_comb begin
            rd[p] = rf_q[ra[p]];
            rv[p] = ~busy_q[ra[p]];
            if ((BYPASS != 0) && !rst) begin
                if (lwe_ok && (bus.lwa == ra[p])) begin
                    rd[p] = bus.lwd;
                    rv[p] = 1'b1;
                end
                if (we_ok && (bus.wa == ra[p])) begin
                    rd[p] = bus.wd;
                end
            end
            if (is_zero(ra[p])) begin
                rd[p] = '0;
                rv[p] = 1'b1;
            end
        end
    end

    assign bus.rd1      = rd[0];
    assign bus.rd2      = rd[1];
    assign bus.rv1      = rv[0];
    assign bus.rv2      = rv[1];
    assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a forwarding (BYPASS=1) and a stored-only (BYPASS=0) instance
// share one stimulus stream and are checked against hand-computed values.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

    assign if_n.ra1 = if_b.ra1;
    assign if_n.ra2 = if_b.ra2;
    assign if_n.we  = if_b.we;
    assign if_n.wa  = if_b.wa;
    assign if_n.wd  = if_b.wd;
    assign if_n.lwe = if_b.lwe;
    assign if_n.lwa = if_b.lwa;
    assign if_n.lwd = if_b.lwd;
    assign if_n.iss = if_b.iss;
    assign if_n.iwa = if_b.iwa;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_b.we  = 1'b0;
        if_b.lwe = 1'b0;
        if_b.iss = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        if_b.ra1 = '0; if_b.ra2 = '0;
        if_b.we  = 1'b0; if_b.wa = '0; if_b.wd = '0;
        if_b.lwe = 1'b0; if_b.lwa = '0; if_b.lwd = '0;
        if_b.iss = 1'b0; if_b.iwa = '0;

        // Reset held: bus stimulus ignored
        if_b.we = 1'b1; if_b.wa = 5'd6; if_b.wd = 32'hFFFF_0000; if_b.ra1 = 5'd6;
        tick(); tick();
        chk("rst_rd1_b", if_b.rd1, 32'h0);
        chk("rst_rv1_b", 32'(if_b.rv1), 32'h1);
        chk("rst_cnt_b", 32'(if_b.busy_cnt), 32'h0);
        idle();
        rst = 1'b0;
        tick();

        // All addresses read zero and valid
        for (int i = 0; i < 32; i++) begin
            if_b.ra1 = 5'(i);
            if_b.ra2 = 5'(31 - i);
            #1;
            chk("init_rd1_b", if_b.rd1, 32'h0);
            chk("init_rv1_b", 32'(if_b.rv1), 32'h1);
            chk("init_rd2_n", if_n.rd2, 32'h0);
            chk("init_rv2_n", 32'(if_n.rv2), 32'h1);
        end
        chk("init_cnt_n", 32'(if_n.busy_cnt), 32'h0);
        chk("rst_write_dropped", if_n.rd1, 32'h0);

        // ALU write, forwarding vs. stored
        if_b.we = 1'b1; if_b.wa = 5'd3; if_b.wd = 32'h1234_5678; if_b.ra1 = 5'd3;
        #1;
        chk("wr_same_b", if_b.rd1, 32'h1234_5678);
        chk("wr_same_n", if_n.rd1, 32'h0);
        tick(); idle(); #1;
        chk("wr_next_n", if_n.rd1, 32'h1234_5678);
        chk("wr_next_b", if_b.rd1, 32'h1234_5678);

        // Both ports to reg 7: port A wins
        if_b.we = 1'b1; if_b.wa = 5'd7; if_b.wd = 32'hA;
        if_b.lwe = 1'b1; if_b.lwa = 5'd7; if_b.lwd = 32'hB; if_b.ra2 = 5'd7;
        #1;
        chk("dual_same_b", if_b.rd2, 32'hA);
        tick(); idle(); #1;
        chk("dual_next_n", if_n.rd2, 32'hA);
        chk("dual_next_b", if_b.rd2, 32'hA);

        // Issue then complete a load to reg 5
        if_b.iss = 1'b1; if_b.iwa = 5'd5; if_b.ra1 = 5'd5;
        #1;
        chk("iss_same_rv_b", 32'(if_b.rv1), 32'h1);
        tick(); idle(); #1;
        chk("iss_next_rv_b", 32'(if_b.rv1), 32'h0);
        chk("iss_next_rv_n", 32'(if_n.rv1), 32'h0);
        chk("iss_cnt_b", 32'(if_b.busy_cnt), 32'h1);
        if_b.lwe = 1'b1; if_b.lwa = 5'd5; if_b.lwd = 32'h55;
        #1;
        chk("ld_same_rv_b", 32'(if_b.rv1), 32'h1);
        chk("ld_same_rd_b", if_b.rd1, 32'h55);
        chk("ld_same_rv_n", 32'(if_n.rv1), 32'h0);
        chk("ld_same_rd_n", if_n.rd1, 32'h0);
        chk("ld_same_cnt_b", 32'(if_b.busy_cnt), 32'h1);
        tick(); idle(); #1;
        chk("ld_next_cnt_b", 32'(if_b.busy_cnt), 32'h0);
        chk("ld_next_rv_n", 32'(if_n.rv1), 32'h1);
        chk("ld_next_rd_n", if_n.rd1, 32'h55);

        // Re-issue and load-complete collide on busy reg 9: stays busy
        if_b.iss = 1'b1; if_b.iwa = 5'd9; if_b.ra1 = 5'd9;
        tick(); idle(); #1;
        chk("r9_cnt", 32'(if_b.busy_cnt), 32'h1);
        if_b.iss = 1'b1; if_b.iwa = 5'd9;
        if_b.lwe = 1'b1; if_b.lwa = 5'd9; if_b.lwd = 32'h99;
        #1;
        chk("r9_same_rv_b", 32'(if_b.rv1), 32'h1);
        tick(); idle(); #1;
        chk("r9_cnt_kept", 32'(if_b.busy_cnt), 32'h1);
        chk("r9_rv_b", 32'(if_b.rv1), 32'h0);
        chk("r9_rd_b", if_b.rd1, 32'h99);
        chk("r9_rd_n", if_n.rd1, 32'h99);

        // Set reg 10 while clearing reg 9: count nets to zero change
        if_b.iss = 1'b1; if_b.iwa = 5'd10; if_b.ra2 = 5'd10;
        if_b.lwe = 1'b1; if_b.lwa = 5'd9; if_b.lwd = 32'h77;
        tick(); idle(); #1;
        chk("swap_cnt", 32'(if_n.busy_cnt), 32'h1);
        chk("swap_rv9_n", 32'(if_n.rv1), 32'h1);
        chk("swap_rd9_n", if_n.rd1, 32'h77);
        chk("swap_rv10_b", 32'(if_b.rv2), 32'h0);
        if_b.lwe = 1'b1; if_b.lwa = 5'd10; if_b.lwd = 32'h10;
        tick(); idle(); #1;
        chk("swap_clr_cnt", 32'(if_b.busy_cnt), 32'h0);

        // Register 0 ignores all traffic
        if_b.we = 1'b1; if_b.wa = 5'd0; if_b.wd = 32'hDEAD_BEEF;
        if_b.lwe = 1'b1; if_b.lwa = 5'd0; if_b.lwd = 32'hCAFE_F00D;
        if_b.iss = 1'b1; if_b.iwa = 5'd0; if_b.ra1 = 5'd0;
        #1;
        chk("z_same_rd_b", if_b.rd1, 32'h0);
        chk("z_same_rv_b", 32'(if_b.rv1), 32'h1);
        tick(); idle(); #1;
        chk("z_cnt_b", 32'(if_b.busy_cnt), 32'h0);
        chk("z_rd_n", if_n.rd1, 32'h0);
        chk("z_rv_n", 32'(if_n.rv1), 32'h1);

        // Fill regs 1..4 and mark them busy, then reset mid-cycle
        for (int i = 1; i <= 4; i++) begin
            if_b.we = 1'b1; if_b.wa = 5'(i); if_b.wd = 32'(32'h100 + i);
            tick();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            if_b.iss = 1'b1; if_b.iwa = 5'(i);
            tick();
        end
        idle();
        if_b.ra1 = 5'd1; if_b.ra2 = 5'd3;
        #1;
        chk("pre_rst_cnt", 32'(if_b.busy_cnt), 32'h4);
        chk("pre_rst_rd1", if_n.rd1, 32'h101);
        chk("pre_rst_rv1", 32'(if_b.rv1), 32'h0);
        rst = 1'b1;
        if_b.we = 1'b1; if_b.wa = 5'd1; if_b.wd = 32'hDEAD;
        #1;
        chk("mid_rst_cnt_b", 32'(if_b.busy_cnt), 32'h0);
        chk("mid_rst_cnt_n", 32'(if_n.busy_cnt), 32'h0);
        chk("mid_rst_rd1_b", if_b.rd1, 32'h0);
        chk("mid_rst_rv1_b", 32'(if_b.rv1), 32'h1);
        chk("mid_rst_rd2_n", if_n.rd2, 32'h0);
        tick();
        chk("held_rst_rd1_b", if_b.rd1, 32'h0);
        idle();
        rst = 1'b0;
        tick();
        chk("post_rst_rd1_n", if_n.rd1, 32'h0);
        chk("post_rst_cnt", 32'(if_b.busy_cnt), 32'h0);

        // First write after reset lands normally
        if_b.we = 1'b1; if_b.wa = 5'd2; if_b.wd = 32'h22; if_b.ra2 = 5'd2;
        tick(); idle(); #1;
        chk("post_rst_wr_n", if_n.rd2, 32'h22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
